// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and widths used by the register file, the ALU and the controller.
package cpu_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS);

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/register_file_if.sv
// Read/write bus between the controller/ALU and the register file.
interface register_file_if;
    import cpu_pkg::*;

    logic      ren;
    reg_addr_t ra_a;
    reg_addr_t ra_b;
    logic      we;
    reg_addr_t wa;
    word_t     wd;
    word_t     A;
    word_t     B;
    logic      wr_zero_err;

    modport master (
        output ren, ra_a, ra_b, we, wa, wd,
        input  A, B, wr_zero_err
    );

    modport slave (
        input  ren, ra_a, ra_b, we, wa, wd,
        output A, B, wr_zero_err
    );

endinterface

// File: rtl/register_file_read_port.sv
// One registered read port: zero-register masking, optional write bypass
// (REGFILE_BYPASS_EN), and an output register that holds while ren is low.
module regfile_read_port
    import cpu_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  word_t     mem [NUM_REGS],
    input  reg_addr_t ra,
    input  logic      ren,
    input  logic      we,
    input  reg_addr_t wa,
    input  word_t     wd,
    output word_t     rd
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    word_t rd_next_c;

    // ra != 0 is checked first, so a bypass hit also implies wa != 0
    always_comb begin
        rd_next_c = '0;
        if (ra != '0) begin
            if (BYPASS && we && (wa == ra)) begin
                rd_next_c = wd;
            end else begin
                rd_next_c = mem[ra];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd <= '0;
        end else if (ren) begin
            rd <= rd_next_c;
        end
    end

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file for the ALU operand buses; r0 reads as zero.
// Same-edge write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module register_file
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    register_file_if.slave   bus
);

    word_t mem [NUM_REGS];
    word_t a_q;
    word_t b_q;
    logic  wr_zero_err_q;

    // Storage; entry 0 is only ever cleared and is masked by the read ports
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                mem[i] <= '0;
            end
        end else if (bus.we && (bus.wa != '0)) begin
            mem[bus.wa] <= bus.wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_zero_err_q <= 1'b0;
        end else begin
            wr_zero_err_q <= bus.we && (bus.wa == '0);
        end
    end

    regfile_read_port u_port_a (
        .clk (clk),
        .rst (rst),
        .mem (mem),
        .ra  (bus.ra_a),
        .ren (bus.ren),
        .we  (bus.we),
        .wa  (bus.wa),
        .wd  (bus.wd),
        .rd  (a_q)
    );

    regfile_read_port u_port_b (
        .clk (clk),
        .rst (rst),
        .mem (mem),
        .ra  (bus.ra_b),
        .ren (bus.ren),
        .we  (bus.we),
        .wa  (bus.wa),
        .wd  (bus.wd),
        .rd  (b_q)
    );

    assign bus.A           = a_q;
    assign bus.B           = b_q;
    assign bus.wr_zero_err = wr_zero_err_q;

endmodule
